fft_result_receiver: RTL and testbench

//  Avalon-ST sink for the FFT core's result stream (real/imag/block exponent, sop/eop, error).

---
 rtl/fft_result_receiver.sv | 183 ++++++++++++++++++
 tb/tb_fft_result_receiver.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_receiver.sv
// Avalon-ST sink for FFT results: frame checking, block-exponent
// denormalisation with saturation, and a 2-entry output skid buffer.
module fft_result_receiver #(
  parameter int FRAME_LEN = 1024,
  parameter int IN_W      = 32,
  parameter int OUT_W     = 32,
  parameter int EXP_W     = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_error,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [IN_W-1:0]  in_real,
  input  logic [IN_W-1:0]  in_imag,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sop,
  output logic             out_eop,
  output logic [OUT_W-1:0] out_real,
  output logic [OUT_W-1:0] out_imag,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic [15:0]      frame_cnt
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  localparam int SH_MAX = 1 << (EXP_W - 1);
  localparam int WW = OUT_W + SH_MAX + 1;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    DROP
  } state_t;

  typedef struct packed {
    logic             sop;
    logic             eop;
    logic [OUT_W-1:0] re;
    logic [OUT_W-1:0] im;
  } beat_t;

  state_t state, nstate;
  logic [CW-1:0] beat, nbeat;
  logic [EXP_W-1:0] exp_q, cur_exp;
  logic signed [EXP_W:0] shamt;
  beat_t slot0, slot1, nb;
  logic [1:0] occ, occ_n, wi;
  logic acc, pop, fwd, fwd_sop, fwd_eop;
  logic err, latch, good_eop;
  logic [1:0] code;

  // Wide intermediate holds any left shift so overflow is seen exactly.
  function automatic logic [OUT_W-1:0] scale(
    input logic [IN_W-1:0]   raw,
    input logic signed [EXP_W:0] s
  );
    logic signed [WW-1:0] wide, hi, lo;
    logic [EXP_W:0] n;
    logic [OUT_W-1:0] r;
    hi = $signed({{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    lo = $signed({{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});
    wide = $signed({{(WW-IN_W){raw[IN_W-1]}}, raw});
    if (s[EXP_W]) begin
      n = $unsigned(-s);
      wide = wide >>> n;
      r = wide[OUT_W-1:0];
    end else begin
      n = $unsigned(s);
      wide = wide <<< n;
      if (wide > hi)
        r = hi[OUT_W-1:0];
      else if (wide < lo)
        r = lo[OUT_W-1:0];
      else
        r = wide[OUT_W-1:0];
    end
    return r;
  endfunction

  assign out_valid = (occ != 2'd0);
  assign out_sop   = slot0.sop;
  assign out_eop   = slot0.eop;
  assign out_real  = slot0.re;
  assign out_imag  = slot0.im;

  always_comb begin
    acc      = in_valid & in_ready;
    pop      = out_valid & out_ready;
    fwd      = 1'b0;
    fwd_sop  = 1'b0;
    fwd_eop  = 1'b0;
    err      = 1'b0;
    code     = 2'd0;
    latch    = 1'b0;
    good_eop = 1'b0;
    nstate   = state;
    nbeat    = beat;
    if (acc) begin
      if (in_error != 2'd0) begin
        err    = 1'b1;
        code   = 2'd3;
        nstate = DROP;
      end else if (in_sop) begin
        if (state == FRAME) begin
          err  = 1'b1;
          code = 2'd1;
        end
        latch   = 1'b1;
        fwd     = 1'b1;
        fwd_sop = 1'b1;
        nbeat   = CW'(1);
        nstate  = FRAME;
      end else if (state == FRAME) begin
        if (in_eop != (beat == LAST)) begin
          err    = 1'b1;
          code   = 2'd2;
          nstate = DROP;
        end else if (in_eop) begin
          fwd      = 1'b1;
          fwd_eop  = 1'b1;
          good_eop = 1'b1;
          nstate   = IDLE;
        end else begin
          fwd   = 1'b1;
          nbeat = beat + CW'(1);
        end
      end
    end
  end

  // The sop beat is scaled with its own exponent, not the stale one.
  always_comb begin
    cur_exp = latch ? in_exp : exp_q;
    shamt   = -$signed({cur_exp[EXP_W-1], cur_exp});
    nb      = {fwd_sop, fwd_eop,
               scale(in_real, shamt),
               scale(in_imag, shamt)};
    occ_n   = occ + {1'b0, fwd} - {1'b0, pop};
    wi      = occ - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      beat      <= '0;
      exp_q     <= '0;
      occ       <= 2'd0;
      slot0     <= '0;
      slot1     <= '0;
      in_ready  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      frame_cnt <= 16'd0;
    end else begin
      state     <= nstate;
      beat      <= nbeat;
      occ       <= occ_n;
      in_ready  <= (occ_n != 2'd2);
      frame_err <= err;
      if (latch)
        exp_q <= in_exp;
      if (err)
        err_code <= code;
      if (good_eop)
        frame_cnt <= frame_cnt + 16'd1;
      if (pop)
        slot0 <= slot1;
      if (fwd) begin
        if (wi == 2'd0)
          slot0 <= nb;
        else
          slot1 <= nb;
      end
    end
  end

endmodule

// File: tb/tb_fft_result_receiver.sv
// Bench for fft_result_receiver: vector table, random backpressure
// against a reference model, and framing/reset corner sequences.
module tb_fft_result_receiver;

  localparam int FL = 8;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [1:0] in_error = 2'd0;
  logic in_sop = 1'b0;
  logic in_eop = 1'b0;
  logic [31:0] in_real = '0;
  logic [31:0] in_imag = '0;
  logic [5:0] in_exp = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic out_sop, out_eop;
  logic [31:0] out_real, out_imag;
  logic frame_err;
  logic [1:0] err_code;
  logic [15:0] frame_cnt;

  fft_result_receiver #(
    .FRAME_LEN(FL),
    .IN_W(32),
    .OUT_W(32),
    .EXP_W(6)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_error(in_error),
    .in_sop(in_sop),
    .in_eop(in_eop),
    .in_real(in_real),
    .in_imag(in_imag),
    .in_exp(in_exp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sop(out_sop),
    .out_eop(out_eop),
    .out_real(out_real),
    .out_imag(out_imag),
    .frame_err(frame_err),
    .err_code(err_code),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sop;
    logic eop;
    logic [31:0] re;
    logic [31:0] im;
  } obeat_t;

  typedef struct {
    logic [5:0]  ex;
    logic [31:0] re;
    logic [31:0] im;
    logic [31:0] xre;
    logic [31:0] xim;
  } vec_t;

  obeat_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int mst = 0;
  int midx = 0;
  int mexp = 0;
  int mfc = 0;
  int mec = 0;
  bit mpulse = 0;
  bit started = 0;
  bit rnd_ready = 0;
  logic [31:0] sop_re = '0;
  logic [31:0] sop_im = '0;

  task automatic check(string name, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // value * 2^(-e), floor on division, clamp to 32-bit signed
  function automatic logic [31:0] mscale(logic [31:0] raw, int e);
    longint v;
    longint d;
    int s;
    v = longint'($signed(raw));
    s = -e;
    if (s >= 0) begin
      for (int i = 0; i < s; i++) begin
        v = v * 2;
        if (v > MAXV) begin
          v = MAXV;
          break;
        end
        if (v < MINV) begin
          v = MINV;
          break;
        end
      end
    end else begin
      d = longint'(1) << (-s);
      if (v >= 0)
        v = v / d;
      else
        v = -((-v + d - 1) / d);
    end
    return v[31:0];
  endfunction

  function automatic obeat_t mk(bit s, bit e);
    obeat_t b;
    b.sop = s;
    b.eop = e;
    b.re = mscale(in_real, mexp);
    b.im = mscale(in_imag, mexp);
    return b;
  endfunction

  // States: 0 idle, 1 in frame, 2 dropping until sop
  task automatic model_accept();
    if (in_error != 2'd0) begin
      mec = 3;
      mpulse = 1;
      mst = 2;
    end else if (in_sop) begin
      if (mst == 1) begin
        mec = 1;
        mpulse = 1;
      end
      mexp = int'($signed(in_exp));
      midx = 1;
      mst = 1;
      q.push_back(mk(1, 0));
    end else if (mst == 1) begin
      if (in_eop != (midx == FL - 1)) begin
        mec = 2;
        mpulse = 1;
        mst = 2;
      end else if (in_eop) begin
        q.push_back(mk(0, 1));
        mfc = (mfc + 1) % 65536;
        mst = 0;
      end else begin
        q.push_back(mk(0, 0));
        midx++;
      end
    end
  endtask

  always @(negedge clk) begin
    obeat_t e;
    if (!reset_n) begin
      check("reset_ctrl",
            {in_ready, out_valid, out_sop, out_eop,
             frame_err, err_code, frame_cnt}, 64'd0);
      check("reset_data", {out_real, out_imag}, 64'd0);
      q.delete();
      mst = 0;
      midx = 0;
      mexp = 0;
      mfc = 0;
      mec = 0;
      mpulse = 0;
      started = 0;
    end else begin
      if (started)
        check("in_ready", in_ready, q.size() < 2);
      else
        started = 1;
      check("out_valid", out_valid, q.size() != 0);
      check("frame_cnt", frame_cnt, mfc);
      check("err_code", err_code, mec);
      check("frame_err", frame_err, mpulse);
      mpulse = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("extra_beat", out_valid, 0);
        end else begin
          e = q.pop_front();
          check("beat_flags", {out_sop, out_eop}, {e.sop, e.eop});
          check("beat_data", {out_real, out_imag}, {e.re, e.im});
          if (out_sop) begin
            sop_re = out_real;
            sop_im = out_imag;
          end
        end
      end
      if (in_valid && in_ready)
        model_accept();
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(bit s, bit e, logic [1:0] er,
                      logic [31:0] re, logic [31:0] im,
                      logic [5:0] ex);
    int k = 0;
    in_valid = 1'b1;
    in_sop = s;
    in_eop = e;
    in_error = er;
    in_real = re;
    in_imag = im;
    in_exp = ex;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready)
      check("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    in_error = 2'd0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int k = 0;
    rnd_ready = 0;
    while ((q.size() != 0 || out_valid) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain", q.size(), 0);
  endtask

  // Non-sop beats carry a different exponent that must be ignored.
  task automatic const_frame(logic [5:0] ex, logic [31:0] re,
                             logic [31:0] im);
    for (int i = 0; i < FL; i++)
      send(i == 0, i == FL - 1, 2'd0, re, im,
           (i == 0) ? ex : ~ex);
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
  endtask

  vec_t tbl[8];

  initial begin
    int good;
    logic [31:0] r;
    logic [5:0] ex;
    tbl[0] = '{6'h3D, 32'd5, 32'hFFFFFFFE, 32'd40, 32'hFFFFFFF0};
    tbl[1] = '{6'h02, 32'hFFFFFFFB, 32'd5, 32'hFFFFFFFE, 32'd1};
    tbl[2] = '{6'h21, 32'd1, 32'hFFFFFFFF,
               32'h7FFFFFFF, 32'h80000000};
    tbl[3] = '{6'h20, 32'd1, 32'd0, 32'h7FFFFFFF, 32'd0};
    tbl[4] = '{6'h1F, 32'hFFFFFFFF, 32'h7FFFFFFF,
               32'hFFFFFFFF, 32'd0};
    tbl[5] = '{6'h00, 32'h80000000, 32'h7FFFFFFF,
               32'h80000000, 32'h7FFFFFFF};
    tbl[6] = '{6'h3F, 32'h40000000, 32'hC0000000,
               32'h7FFFFFFF, 32'h80000000};
    tbl[7] = '{6'h01, 32'hFFFFFFFD, 32'd3, 32'hFFFFFFFE, 32'd1};

    idle(3);
    reset_n = 1'b1;
    idle(2);

    // Ramp frame, unity exponent
    for (int i = 0; i < FL; i++) begin
      send(i == 0, i == FL - 1, 2'd0, i, 100 + i, 6'd0);
      if (i == 0)
        check("t1_latency", {out_valid, out_sop, out_real},
              {1'b1, 1'b1, 32'd0});
    end
    drain();
    check("t1_frame_cnt", frame_cnt, 1);

    foreach (tbl[i]) begin
      const_frame(tbl[i].ex, tbl[i].re, tbl[i].im);
      drain();
      check("tbl_real", sop_re, tbl[i].xre);
      check("tbl_imag", sop_im, tbl[i].xim);
    end
    good = 1 + 8;

    // Random data and exponents under random backpressure
    rnd_ready = 1;
    for (int f = 0; f < 3; f++) begin
      ex = 6'($urandom);
      for (int i = 0; i < FL; i++) begin
        r = $urandom;
        send(i == 0, i == FL - 1, 2'd0,
             32'($signed(r) >>> $urandom_range(0, 31)),
             $urandom, ex);
        if ($urandom_range(0, 3) == 0)
          idle($urandom_range(1, 2));
      end
    end
    drain();
    good = good + 3;
    check("rand_frame_cnt", frame_cnt, good);

    // Early eop on beat 5, stragglers dropped
    for (int i = 0; i < FL; i++)
      send(i == 0, i == 5, 2'd0, i, i, 6'd0);
    drain();
    check("t4_err_code", err_code, 2);
    check("t4_frame_cnt", frame_cnt, good);
    const_frame(6'd0, 32'd7, 32'd9);
    drain();
    good++;

    // sop inside an open frame restarts it
    for (int i = 0; i < 3; i++)
      send(i == 0, 0, 2'd0, i, i, 6'd0);
    const_frame(6'h3E, 32'd3, 32'hFFFFFFFD);
    drain();
    good++;
    check("t5_err_code", err_code, 1);
    check("t5_frame_cnt", frame_cnt, good);

    // Core error on beat 2, then reset mid-frame
    for (int i = 0; i < FL; i++)
      send(i == 0, i == FL - 1, (i == 2) ? 2'b01 : 2'b00,
           i, i, 6'd0);
    drain();
    check("t6_err_code", err_code, 3);
    for (int i = 0; i < 3; i++)
      send(i == 0, 0, 2'd0, i, i, 6'd0);
    pulse_reset();
    check("t6_after_reset",
          {out_valid, frame_err, err_code, frame_cnt}, 64'd0);
    for (int i = 3; i < FL; i++)
      send(0, i == FL - 1, 2'd0, i, i, 6'd0);
    drain();
    check("t6_dropped", {out_valid, frame_cnt}, 64'd0);
    const_frame(6'd0, 32'd11, 32'd12);
    drain();
    check("t6_frame_cnt", frame_cnt, 1);
    check("t6_clean_real", sop_re, 32'd11);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
